// File: rtl/wb_stage_if.sv
// Execute-to-writeback handshake bundle: one completed instruction per accept.
// The execute stage drives the master side, wb_stage the slave side.
interface wb_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0] ex_result;
  logic                  ex_is_load;
  logic [2:0]            ex_ld_fmt;
  logic [1:0]            ex_addr_lo;

  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_fmt, ex_addr_lo,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_fmt, ex_addr_lo,
    output ex_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly, parks loads until the memory
// response arrives, formats load data and drives the register file write port.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_stage_if.slave             ex,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit,
  output logic                  busy_valid,
  output logic [ADDR_WIDTH-1:0] busy_rd,
  output logic                  err
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  logic [0:0]            state_reg;
  logic [ADDR_WIDTH-1:0] ld_rd_reg;
  logic [2:0]            ld_fmt_reg;
  logic [1:0]            ld_lo_reg;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data_next;
  logic                  ld_err_next;

  assign ex.ex_ready = (state_reg == IDLE);

  // Right shift zero-fills the vacated high bytes before any extension.
  assign shifted = mem_rdata >> {ld_lo_reg, 3'b000};

  always_comb begin
    ld_data_next = shifted;
    ld_err_next  = 1'b0;
    case (ld_fmt_reg)
      3'b000: ld_data_next = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b100: ld_data_next = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b001: begin
        ld_data_next = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        ld_err_next  = (ld_lo_reg == 2'd3);
      end
      3'b101: begin
        ld_data_next = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
        ld_err_next  = (ld_lo_reg == 2'd3);
      end
      3'b010: ld_err_next = (ld_lo_reg != 2'd0);
      // Reserved encodings fall back to a word load but are flagged.
      default: ld_err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ld_rd_reg  <= '0;
      ld_fmt_reg <= '0;
      ld_lo_reg  <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      commit     <= 1'b0;
      busy_valid <= 1'b0;
      busy_rd    <= '0;
      err        <= 1'b0;
    end else begin
      rf_wen <= 1'b0;
      commit <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A stray response with nothing outstanding is only recorded.
          if (mem_rvalid) err <= 1'b1;
          if (ex.ex_valid) begin
            if (ex.ex_is_load) begin
              state_reg  <= WAIT_MEM;
              ld_rd_reg  <= ex.ex_rd;
              ld_fmt_reg <= ex.ex_ld_fmt;
              ld_lo_reg  <= ex.ex_addr_lo;
              busy_valid <= 1'b1;
              busy_rd    <= ex.ex_rd;
            end else begin
              rf_wen   <= (ex.ex_rd != '0);
              rf_waddr <= ex.ex_rd;
              rf_wdata <= ex.ex_result;
              commit   <= 1'b1;
            end
          end
        end
        default: begin
          if (mem_rvalid) begin
            state_reg  <= IDLE;
            rf_wen     <= (ld_rd_reg != '0);
            rf_waddr   <= ld_rd_reg;
            rf_wdata   <= ld_data_next;
            commit     <= 1'b1;
            busy_valid <= 1'b0;
            busy_rd    <= '0;
            if (ld_err_next) err <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage sitting directly upstream of the NPC register file.
- Accepts completed results from the execute/LSU stage over a valid/ready handshake. Waits for load data where needed, then extracts and extends load data.
- Drives the register file single write port (wen/waddr/wdata), suppresses writes to x0, and reports commit and hazard information to the core.

Parameters:
- ADDR_WIDTH, 5, register index width; must match the register file.
- DATA_WIDTH, 32, data width; load lane extraction is defined for 32 only.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ex_valid  input  1  execute stage presents a result.
- ex_ready  output  1  stage can accept; equals (state==IDLE).
- ex_rd  input  ADDR_WIDTH  destination register.
- ex_result  input  DATA_WIDTH  ALU/CSR result; ignored for loads.
- ex_is_load  input  1  instruction is a load; data arrives via mem_rvalid.
- ex_ld_fmt  input  3  load funct3.
- ex_addr_lo  input  2  load address bits [1:0].
- mem_rvalid  input  1  load data response valid (single-cycle pulse).
- mem_rdata  input  DATA_WIDTH  raw aligned memory word.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  ADDR_WIDTH  register file write address.
- rf_wdata  output  DATA_WIDTH  register file write data.
- commit  output  1  one-cycle pulse per retired instruction, including rd==0.
- busy_valid  output  1  load in flight (state==WAIT_MEM).
- busy_rd  output  ADDR_WIDTH  rd of in-flight load; decode uses it for stall.
- err  output  1  sticky error flag.

Behaviour:
- Reset values:
  - Outputs: rf_wen=0, rf_waddr=0, rf_wdata=0, commit=0, busy_valid=0, busy_rd=0, err=0.
  - State: IDLE.
- All outputs except ex_ready are registered.
- Accept condition: ex_valid && ex_ready at posedge T.
- FSM states: IDLE, WAIT_MEM.
  - IDLE, accept, !ex_is_load:
    - At T+1: rf_wen=(ex_rd!=0), rf_waddr=ex_rd, rf_wdata=ex_result, commit=1.
    - Stays IDLE, so back-to-back accepts give one write per cycle.
  - IDLE, accept, ex_is_load:
    - Latch rd, fmt, addr_lo; go to WAIT_MEM.
    - rf_wen=0 and commit=0 at T+1.
    - busy_valid=1 and busy_rd=rd from T+1.
  - WAIT_MEM:
    - ex_ready=0.
    - On mem_rvalid at edge M: rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=formatted data, and commit=1 at M+1.
    - Returns to IDLE at M+1; busy_valid=0 and ex_ready=1 at M+1.
  - WAIT_MEM with no mem_rvalid: holds indefinitely; no timeout.
- Load formatting: shift s = mem_rdata >> (8*addr_lo).
  - 000 lb: sign-extend s[7:0].
  - 100 lbu: zero-extend s[7:0].
  - 001 lh: sign-extend s[15:0].
  - 101 lhu: zero-extend s[15:0].
  - 010 lw: s (no shift when aligned).
  - Vacated high bytes from the shift are zero-filled before extension.
- Errors: err is set and stays set until reset in each of these cases.
  - fmt in {011, 110, 111}: treated as lw.
  - Misaligned access: lh/lhu with addr_lo==3, or lw with addr_lo!=0.
  - The write is still performed with the formatted data.
  - mem_rvalid while in IDLE: also sets err; the response is otherwise ignored, with no write and no commit.
- x0: rf_wen is never asserted with rf_waddr==0; commit still pulses.
- Pulses: rf_wen and commit are single-cycle unless a new accept occurs.
- Reset mid-operation: reset in any cycle forces IDLE.
  - Any in-flight load is dropped.
  - A mem_rvalid or accept in the reset cycle has no effect.
  - At the next cycle, all outputs are at reset values and ex_ready=1.

Test Plan:
- After reset: ALU accept rd=5, result=0xDEADBEEF at T -> at T+1 rf_wen=1, waddr=5, wdata=0xDEADBEEF, commit=1; at T+2 rf_wen=0.
- Three back-to-back ALU accepts rd=1,2,0 -> writes on three consecutive cycles; third cycle has rf_wen=0 and commit=1.
- lb rd=7, addr_lo=2, mem_rdata=0x12804567 returned 3 cycles after accept:
  - ex_ready=0 and busy_valid=1, busy_rd=7 while waiting.
  - Write cycle: wdata=0xFFFFFF80.
  - Repeat as lbu -> 0x00000080.
  - Repeat lhu with addr_lo=2 -> 0x00001280.
- lw with addr_lo=1, mem_rdata=0xAABBCCDD -> wdata=0x00AABBCC and err=1; err persists through later clean ops until reset.
- Load accepted, then reset asserted during WAIT_MEM with mem_rvalid in the same cycle -> no write, no commit, busy_valid=0, ex_ready=1 next cycle; a following ALU op writes normally.
- mem_rvalid pulsed in IDLE -> no rf_wen, no commit, err=1.
